noc_eject_ni: RTL

// - Ejection-side network interface: sits on a router's local_out port and delivers packets to the attached core.
// - Buffers incoming flits and credits them back to the router.
// - Checks head/body/tail framing, length and destination.
// - Presents payloads as a valid/ready stream with sop/eop markers.
// - Counterpart of the core-side injector that drives the router's local_in port.

---
 rtl/noc_eject_ni.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/noc_eject_ni.sv
// Ejection network interface: buffers router flits, returns credits, checks framing and emits a sop/eop stream.
// Optional NOC_EJECT_STATS_EN adds pkt_cnt/err_cnt counters of delivered and errored packets.
//   state | meaning
//   IDLE  | waiting for a head flit; stray body/tail flits are discarded
//   RECV  | inside a packet, rem flits still expected
module noc_eject_ni #(
    parameter int x_size     = 4,
    parameter int y_size     = 4,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_WIDTH = 64,
    parameter int FLIT_WIDRH = 2 + 5 + $clog2(x_size) + $clog2(y_size) + DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDRH-1:0] flit_in,
    output logic                  credit_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  out_err,
    output logic                  ovf_err
`ifdef NOC_EJECT_STATS_EN
    ,
    output logic [15:0]           pkt_cnt,
    output logic [15:0]           err_cnt
`endif
);

    localparam int XW = $clog2(x_size);
    localparam int YW = $clog2(y_size);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_BODY = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b11;

    typedef enum logic {IDLE, RECV} state_t;

    logic [FLIT_WIDRH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  empty;
    logic                  full;
    logic                  in_present;
    logic                  wr_en;
    logic                  pop;
    logic                  trunc;

    logic [FLIT_WIDRH-1:0] h_flit;
    logic [1:0]            h_type;
    logic [4:0]            h_len;
    logic [XW-1:0]         h_dx;
    logic [YW-1:0]         h_dy;
    logic [DATA_WIDTH-1:0] h_data;
    logic                  dst_ok;

    state_t                state;
    state_t                state_nxt;
    logic [4:0]            rem;
    logic [4:0]            rem_nxt;
    logic                  bad;
    logic                  bad_nxt;

    assign in_present = (flit_in[FLIT_WIDRH-1 -: 2] != 2'b00);
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop in the same cycle frees the slot, so a write into a full buffer still lands.
    assign wr_en      = in_present && (!full || pop);

    assign h_flit = mem[rd_ptr[AW-1:0]];
    assign h_type = h_flit[FLIT_WIDRH-1 -: 2];
    assign h_len  = h_flit[FLIT_WIDRH-3 -: 5];
    assign h_dx   = h_flit[DATA_WIDTH+YW +: XW];
    assign h_dy   = h_flit[DATA_WIDTH +: YW];
    assign h_data = h_flit[DATA_WIDTH-1:0];
    assign dst_ok = (h_dx == XW'(MY_X)) && (h_dy == YW'(MY_Y));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= flit_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ovf_err    <= 1'b0;
            credit_out <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (in_present && full && !pop) begin
                ovf_err <= 1'b1;
            end
            credit_out <= pop;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            rem   <= '0;
            bad   <= 1'b0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            bad   <= bad_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        bad_nxt   = bad;
        case (state)
            IDLE: begin
                if (pop && h_type == T_HEAD && h_len != 5'd0) begin
                    state_nxt = RECV;
                    rem_nxt   = h_len;
                    bad_nxt   = !dst_ok;
                end
            end
            RECV: begin
                if (trunc && out_ready) begin
                    state_nxt = IDLE;
                end else if (pop) begin
                    rem_nxt = rem - 5'd1;
                    if (out_eop) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_err   = 1'b0;
        pop       = 1'b0;
        trunc     = 1'b0;
        if (!empty) begin
            case (state)
                IDLE: begin
                    if (h_type == T_HEAD) begin
                        out_valid = 1'b1;
                        out_sop   = 1'b1;
                        out_data  = h_data;
                        out_eop   = (h_len == 5'd0);
                        out_err   = (h_len == 5'd0) && !dst_ok;
                        pop       = out_ready;
                    end else begin
                        pop = 1'b1;
                    end
                end
                RECV: begin
                    // A head mid-packet closes the current packet with an error beat and stays queued.
                    if (h_type == T_HEAD) begin
                        out_valid = 1'b1;
                        out_eop   = 1'b1;
                        out_err   = 1'b1;
                        trunc     = 1'b1;
                    end else begin
                        out_valid = 1'b1;
                        out_data  = h_data;
                        out_eop   = (rem == 5'd1) || (h_type == T_TAIL);
                        out_err   = ((rem == 5'd1) || (h_type == T_TAIL)) &&
                                    (bad || (h_type == T_TAIL && rem != 5'd1) ||
                                     (h_type == T_BODY && rem == 5'd1));
                        pop       = out_ready;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NOC_EJECT_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else if (out_valid && out_ready && out_eop) begin
            pkt_cnt <= pkt_cnt + 16'd1;
            if (out_err) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
